// File: rtl/alu_cmd_stage.sv
// Command FIFO in front of a combinational 4-bit ALU, with a registered
// result stage (valid/ready) and a sticky illegal-opcode flag.
module alu_cmd_stage #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_a,
  input  logic [3:0]              cmd_b,
  input  logic [2:0]              cmd_op,
  output logic [2:0]              alu_a,
  output logic [3:0]              alu_b,
  output logic [2:0]              alu_opcode,
  input  logic [3:0]              alu_result,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [3:0]              res_data,
  output logic [2:0]              res_op,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    err_sticky,
  input  logic                    err_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = 10;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             res_valid_q, res_valid_d;
  logic [3:0]       res_data_q, res_data_d;
  logic [2:0]       res_op_q, res_op_d;
  logic             err_q, err_d;

  logic             push;
  logic             issue;
  logic             out_free;
  logic             fifo_empty;
  logic [ENT_W-1:0] head;
  logic [2:0]       head_op;

  assign fifo_empty = (level_q == '0);
  assign cmd_ready  = (level_q != LVL_W'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign out_free   = !res_valid_q || res_ready;
  assign issue      = !fifo_empty && out_free;
  assign head       = mem_q[rd_ptr_q];
  assign head_op    = head[2:0];

  // Stage 0: FIFO head presented to the ALU (zeros when nothing is queued)
  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;
    if (!fifo_empty) begin
      alu_a      = head[9:7];
      alu_b      = head[6:3];
      alu_opcode = head_op;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push)
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (issue)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, issue})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Stage 1: result capture; data and opcode hold once consumed
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    err_d       = err_q;
    if (issue) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_result;
      res_op_d    = head_op;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
    if (err_clr)
      err_d = 1'b0;
    // A fresh illegal issue overrides a same-cycle clear
    if (issue && (head_op > 3'd4))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_op};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      err_q       <= err_d;
    end
  end

  assign level      = level_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_op     = res_op_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_alu_cmd_stage.sv
// Bench for alu_cmd_stage: directed steps plus randomized traffic, checked
// against an in-order command scoreboard and a behavioural ALU model.
module tb_alu_cmd_stage;

  typedef struct packed {
    logic [2:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  logic [2:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opcode;
  logic [3:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [2:0] res_op;
  logic [2:0] level;
  logic       err_sticky;
  logic       err_clr;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_pushed = 0;
  bit   last_push;
  cmd_t acc_q[$];

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_fn(input logic [2:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    int ua, ub;
    ua = int'(a);
    ub = int'(b);
    case (op)
      3'd0:    return 4'((ua + ub) % 16);
      3'd1:    return 4'((ua - ub + 16) % 16);
      3'd2:    return {1'b0, a} & b;
      3'd3:    return {1'b0, a} | b;
      3'd4:    return (ua < ub) ? 4'd1 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_opcode);

  alu_cmd_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .level(level), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic v, input logic [2:0] a, input logic [3:0] b,
                         input logic [2:0] op);
    cmd_valid = v;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
  endtask

  // One clock: record handshakes before the edge, check afterwards.
  task automatic step();
    bit         taken, held;
    logic [3:0] hd;
    logic [2:0] ho;
    cmd_t       c;
    last_push = cmd_valid && cmd_ready;
    taken     = res_valid && res_ready;
    held      = res_valid && !res_ready;
    hd        = res_data;
    ho        = res_op;
    if (last_push) begin
      acc_q.push_back(cmd_t'({cmd_a, cmd_b, cmd_op}));
      n_pushed++;
    end
    if (taken) begin
      if (acc_q.size() == 0) begin
        chk("sb_spurious_result", 1, 0);
      end else begin
        c = acc_q.pop_front();
        chk("sb_res_data", res_data, alu_fn(c.a, c.b, c.op));
        chk("sb_res_op", res_op, c.op);
      end
    end
    @(posedge clk);
    #1;
    if (held) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, hd);
      chk("hold_op", res_op, ho);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_op"}, res_op, 0);
    chk({tag, "_err"}, err_sticky, 0);
    chk({tag, "_alu"}, {alu_a, alu_b, alu_opcode}, 0);
  endtask

  initial begin
    logic [3:0] exp_b2b [4];
    int         base;
    int         sent;
    int         guard;

    rst_n = 1'b0;
    res_ready = 1'b1;
    err_clr = 1'b0;
    set_cmd(1'b0, 3'd0, 4'd0, 3'd0);
    #2;
    chk_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD 3+5
    set_cmd(1'b1, 3'd3, 4'd5, 3'd0);
    step();
    set_cmd(1'b0, 3'd0, 4'd0, 3'd0);
    chk("add_alu_a", alu_a, 3);
    chk("add_alu_b", alu_b, 5);
    chk("add_level1", level, 1);
    chk("add_not_yet_valid", res_valid, 0);
    step();
    chk("add_res_valid", res_valid, 1);
    chk("add_res_data", res_data, 8);
    chk("add_res_op", res_op, 0);
    chk("add_level0", level, 0);
    step();
    chk("add_drained", res_valid, 0);

    // Back-to-back SUB, AND, OR, SLT
    exp_b2b = '{4'd13, 4'd4, 4'd9, 4'd1};
    set_cmd(1'b1, 3'd2, 4'd5, 3'd1);  step();
    set_cmd(1'b1, 3'd7, 4'd12, 3'd2); step();
    chk("b2b_0", res_data, exp_b2b[0]);
    set_cmd(1'b1, 3'd1, 4'd8, 3'd3);  step();
    chk("b2b_1", res_data, exp_b2b[1]);
    set_cmd(1'b1, 3'd1, 4'd2, 3'd4);  step();
    chk("b2b_2", res_data, exp_b2b[2]);
    set_cmd(1'b0, 3'd0, 4'd0, 3'd0);  step();
    chk("b2b_3", res_data, exp_b2b[3]);
    chk("b2b_3_valid", res_valid, 1);
    step();

    // Backpressure: 6 offered, DEPTH+1 = 5 buffered
    res_ready = 1'b0;
    base = n_pushed;
    for (int i = 0; i < 6; i++) begin
      set_cmd(1'b1, 3'($urandom), 4'($urandom), 3'($urandom_range(0, 4)));
      step();
    end
    chk("bp_accepted", n_pushed - base, 5);
    chk("bp_cmd_ready_low", cmd_ready, 0);
    chk("bp_level_full", level, 4);
    set_cmd(1'b0, 3'd0, 4'd0, 3'd0);
    res_ready = 1'b1;
    step();
    chk("bp_ready_back", cmd_ready, 1);
    chk("bp_level3", level, 3);
    guard = 0;
    while (acc_q.size() > 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("bp_drained", acc_q.size(), 0);
    chk("bp_idle", res_valid, 0);

    // Illegal opcode and sticky error
    set_cmd(1'b1, 3'd5, 4'd9, 3'd6); step();
    set_cmd(1'b0, 3'd0, 4'd0, 3'd0); step();
    chk("ill_res_data", res_data, 0);
    chk("ill_res_op", res_op, 6);
    chk("ill_err_set", err_sticky, 1);
    step();
    chk("ill_err_held", err_sticky, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("ill_err_cleared", err_sticky, 0);
    set_cmd(1'b1, 3'd2, 4'd3, 3'd7); step();
    set_cmd(1'b0, 3'd0, 4'd0, 3'd0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("ill_set_wins", err_sticky, 1);
    chk("ill7_res_op", res_op, 7);
    step();

    // Random traffic: 9 commands, random backpressure, pointers wrap
    sent = 0;
    guard = 0;
    while (sent < 9 && guard < 300) begin
      set_cmd(($urandom % 4) != 0, 3'($urandom), 4'($urandom), 3'($urandom));
      res_ready = $urandom % 2;
      step();
      if (last_push) sent++;
      guard++;
    end
    chk("rnd_all_sent", sent, 9);
    set_cmd(1'b0, 3'd0, 4'd0, 3'd0);
    res_ready = 1'b1;
    guard = 0;
    while (acc_q.size() > 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("rnd_drained", acc_q.size(), 0);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // Asynchronous reset mid-stream
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, 3'(i + 1), 4'(i + 2), 3'd0);
      step();
    end
    set_cmd(1'b0, 3'd0, 4'd0, 3'd0);
    chk("ar_level3", level, 3);
    chk("ar_valid", res_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    acc_q.delete();
    #2;
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    set_cmd(1'b1, 3'd3, 4'd5, 3'd0); step();
    set_cmd(1'b0, 3'd0, 4'd0, 3'd0);
    chk("post_level1", level, 1);
    step();
    chk("post_res_data", res_data, 8);
    chk("post_res_valid", res_valid, 1);
    step();
    chk("post_empty", acc_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
